dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, 7, data-memory word-address width.
REQ-002 Parameter DW, 32, data word width.
REQ-003 Parameter TURN, 1, idle cycles forced between a write access and a following read access (0 or 1).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 m0_req / m1_req  input  1  requester 0 (CPU) / requester 1 (debug/DMA) access request.
REQ-007 m0_we / m1_we  input  1  1 = write, 0 = read; valid while req high.
REQ-008 m0_addr / m1_addr  input  AW  word address.
REQ-009 m0_wdata / m1_wdata  input  DW  write data.
REQ-010 m0_gnt / m1_gnt  output  1  combinational grant; request accepted at the rising edge ending a cycle with req&gnt.
REQ-011 m0_rvalid / m1_rvalid  output  1  read data valid, one cycle.
REQ-012 m0_rdata / m1_rdata  output  DW  read data, equal to Q; valid only with rvalid.
REQ-013 CEN  output  1  SRAM chip enable, active-low, registered.
REQ-014 WEN  output  1  SRAM write enable, active-low, registered.
REQ-015 OEN  output  1  SRAM output enable, active-low, registered.
REQ-016 A  output  AW  SRAM address, registered.
REQ-017 D  output  DW  SRAM write data, registered.
REQ-018 Q  input  DW  SRAM read data, valid in the cycle after a read strobe.

Function
REQ-019 Requesters hold req/we/addr/wdata stable from assertion until acceptance; deasserting req before gnt withdraws the request.
REQ-020 At most one gnt is high per cycle; gnt only asserts for a requester with req high.
REQ-021 Arbitration: round-robin; a priority pointer selects the favoured requester when both request; after an acceptance, the pointer moves to the other requester.
REQ-022 Sole requester is granted regardless of pointer, unless blocked by REQ-025.
REQ-023 Acceptance in cycle T drives strobes in T+1: read -> CEN=0, OEN=0, WEN=1; write -> CEN=0, WEN=0, OEN=1; A=addr; D=wdata for writes (D holds previous value on reads).
REQ-024 Cycles with no acceptance drive CEN=1, WEN=1, OEN=1 in the next cycle; A and D hold their values.
REQ-025 FSM states IDLE, ACC, TURN: IDLE/ACC -> ACC on acceptance, -> IDLE otherwise; ACC (write issued) -> TURN if TURN=1 and a read is selected; in TURN all gnt=0 for one cycle, then -> IDLE.
REQ-026 Write-after-write, read-after-read, write-after-read: back-to-back, one access per cycle.
REQ-027 Read accepted in T: owner's rvalid=1 in T+2 with rdata=Q; other requester's rvalid=0.
REQ-028 Owner tag for reads is pipelined per access; two consecutive reads from different requesters return in order, one per cycle.
REQ-029 Writes produce no rvalid.
REQ-030 A requester holding req high after acceptance is a new request and is arbitrated normally.

Reset
REQ-031 While rst_n=0 at a clock edge: CEN=WEN=OEN=1, A=0, D=0, FSM=IDLE, pointer favours m0, all read-owner tags cleared.
REQ-032 gnt outputs are 0 while rst_n=0.
REQ-033 Reset during an outstanding read cancels it: no rvalid asserts after the reset edge.

Verification
REQ-034 m0 read addr 0x05 alone, Q=0xDEADBEEF in T+2 -> m0_gnt in T; CEN=0,OEN=0,A=0x05 in T+1; m0_rvalid=1, m0_rdata=0xDEADBEEF in T+2.
REQ-035 m0 and m1 both request reads continuously from reset -> grants alternate m0,m1,m0,m1; rvalid alternates with matching order two cycles later.
REQ-036 m1 write addr 0x10 data 0x12345678 in T, m0 read addr 0x10 pending, TURN=1 -> WEN=0,D=0x12345678 in T+1; no gnt in T+1; m0 gnt in T+2; OEN=0 in T+3.
REQ-037 Same as REQ-036 with TURN=0 -> m0 gnt in T+1, read strobe in T+2.
REQ-038 m0 read accepted in T, rst_n=0 sampled at end of T+1 -> no m0_rvalid in T+2; CEN=WEN=OEN=1, A=0 after reset.
REQ-039 m1 requests then drops req before gnt while m0 streams -> m1 never granted, no m1 strobe issued.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data SRAM.
// Round-robin grant between m0 (CPU) and m1 (debug/DMA). The SRAM strobes
// are registered, so an access accepted in cycle T is strobed in T+1. Read
// data from the SRAM appears one cycle after the strobe, in T+2. Optional
// write-to-read turnaround: when TURN is set, a read may not be granted in
// the cycle that directly follows a write acceptance.
module dmem_arbiter #(
    parameter int AW   = 7,
    parameter int DW   = 32,
    parameter int TURN = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    // requester 0 (CPU)
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    // requester 1 (debug/DMA)
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    // SRAM port, all control active-low
    output logic          CEN,
    output logic          WEN,
    output logic          OEN,
    output logic [AW-1:0] A,
    output logic [DW-1:0] D,
    input  logic [DW-1:0] Q
);

    // S_IDLE : nothing was accepted in the previous cycle
    // S_ACC  : a read, or a write with no turnaround, was accepted last cycle
    // S_TRN  : a write was accepted last cycle and turnaround is enabled;
    //          this is the cycle in which a selected read is held off
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_TRN  = 2'd2
    } state_e;

    localparam bit TURN_EN = (TURN != 0);

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;        // favoured requester when both ask
    logic          cen_q, cen_d;
    logic          wen_q, wen_d;
    logic          oen_q, oen_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] d_q, d_d;

    // read-owner pipeline: stage 1 lines up with the strobe cycle,
    // stage 2 with the cycle in which Q carries the data
    logic          rd1_v_q, rd1_v_d;
    logic          rd1_id_q, rd1_id_d;
    logic          rd2_v_q, rd2_v_d;
    logic          rd2_id_q, rd2_id_d;

    // arbitration outcome for the current cycle
    logic          sel_v;
    logic          sel_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          block;
    logic          acc;

    // Pick a candidate: the pointer decides a tie, a sole requester wins outright.
    always_comb begin
        sel_v     = m0_req | m1_req;
        sel_id    = (m0_req & m1_req) ? ptr_q : ~m0_req;
        sel_we    = sel_id ? m1_we    : m0_we;
        sel_addr  = sel_id ? m1_addr  : m0_addr;
        sel_wdata = sel_id ? m1_wdata : m0_wdata;
        // a read directly behind a write is held off for one cycle; the
        // pointer is not moved, so the same read wins the following cycle
        block     = (state_q == S_TRN) && !sel_we;
        acc       = rst_n && sel_v && !block;
    end

    // State register (synchronous reset).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every acceptance re-enters ACC, or TRN for a write with turnaround.
    always_comb begin
        state_d = S_IDLE;
        if (acc) begin
            state_d = (sel_we && TURN_EN) ? S_TRN : S_ACC;
        end
    end

    // Grant outputs: at most one, and only for the requester that was accepted.
    always_comb begin
        m0_gnt = acc & ~sel_id;
        m1_gnt = acc &  sel_id;
    end

    // Next values of the pointer, SRAM strobes and read-owner pipeline.
    always_comb begin
        ptr_d    = ptr_q;
        cen_d    = 1'b1;
        wen_d    = 1'b1;
        oen_d    = 1'b1;
        a_d      = a_q;
        d_d      = d_q;
        rd1_v_d  = 1'b0;
        rd1_id_d = rd1_id_q;
        rd2_v_d  = rd1_v_q;
        rd2_id_d = rd1_id_q;
        if (acc) begin
            ptr_d = ~sel_id;
            cen_d = 1'b0;
            wen_d = ~sel_we;
            oen_d = sel_we;
            a_d   = sel_addr;
            if (sel_we) begin
                d_d = sel_wdata;
            end else begin
                rd1_v_d  = 1'b1;
                rd1_id_d = sel_id;
            end
        end
    end

    // Registered SRAM port, pointer and read-owner tags; reset cancels reads in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q    <= 1'b0;
            cen_q    <= 1'b1;
            wen_q    <= 1'b1;
            oen_q    <= 1'b1;
            a_q      <= '0;
            d_q      <= '0;
            rd1_v_q  <= 1'b0;
            rd1_id_q <= 1'b0;
            rd2_v_q  <= 1'b0;
            rd2_id_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            cen_q    <= cen_d;
            wen_q    <= wen_d;
            oen_q    <= oen_d;
            a_q      <= a_d;
            d_q      <= d_d;
            rd1_v_q  <= rd1_v_d;
            rd1_id_q <= rd1_id_d;
            rd2_v_q  <= rd2_v_d;
            rd2_id_q <= rd2_id_d;
        end
    end

    // Drive the SRAM port and return read data to the owner of the access.
    always_comb begin
        CEN       = cen_q;
        WEN       = wen_q;
        OEN       = oen_q;
        A         = a_q;
        D         = d_q;
        m0_rvalid = rd2_v_q & ~rd2_id_q;
        m1_rvalid = rd2_v_q &  rd2_id_q;
        m0_rdata  = Q;
        m1_rdata  = Q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (turnaround on / off) driven by
// directed scenarios followed by random traffic, checked every cycle against
// a transaction-level model of the arbitration and SRAM timing rules.
module tb_dmem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req   [2][2];
    logic          we    [2][2];
    logic [AW-1:0] addr  [2][2];
    logic [DW-1:0] wdata [2][2];
    logic          gnt   [2][2];
    logic          rvalid[2][2];
    logic [DW-1:0] rdata [2][2];
    logic          cen[2], wen[2], oen[2];
    logic [AW-1:0] a[2];
    logic [DW-1:0] d[2], q[2];

    dmem_arbiter #(.AW(AW), .DW(DW), .TURN(1)) u_turn1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
        .m0_gnt(gnt[0][0]), .m0_rvalid(rvalid[0][0]), .m0_rdata(rdata[0][0]),
        .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
        .m1_gnt(gnt[0][1]), .m1_rvalid(rvalid[0][1]), .m1_rdata(rdata[0][1]),
        .CEN(cen[0]), .WEN(wen[0]), .OEN(oen[0]), .A(a[0]), .D(d[0]), .Q(q[0])
    );

    dmem_arbiter #(.AW(AW), .DW(DW), .TURN(0)) u_turn0 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
        .m0_gnt(gnt[1][0]), .m0_rvalid(rvalid[1][0]), .m0_rdata(rdata[1][0]),
        .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
        .m1_gnt(gnt[1][1]), .m1_rvalid(rvalid[1][1]), .m1_rdata(rdata[1][1]),
        .CEN(cen[1]), .WEN(wen[1]), .OEN(oen[1]), .A(a[1]), .D(d[1]), .Q(q[1])
    );

    // requester intents, applied to the pins at the start of each cycle
    logic          i_rst;
    logic [DW-1:0] i_q;
    logic          i_req  [2][2];
    logic          i_we   [2][2];
    logic [AW-1:0] i_addr [2][2];
    logic [DW-1:0] i_wdata[2][2];
    logic          i_auto [2][2];   // issue a fresh request right after acceptance
    int            i_mode;          // 0 random, 1 reads only, 2 writes only

    // reference model state, one copy per instance
    bit            turn_en[2] = '{1'b1, 1'b0};
    logic          m_ptr[2], m_prevwr[2];
    logic          m_cen[2], m_wen[2], m_oen[2];
    logic [AW-1:0] m_a[2];
    logic [DW-1:0] m_d[2];
    logic          m_rd1v[2], m_rd1id[2], m_rd2v[2], m_rd2id[2];
    logic          acc_v[2], acc_id[2], acc_we[2];
    logic [AW-1:0] acc_addr[2];
    logic [DW-1:0] acc_wdata[2];
    logic          last_rst;

    int total = 0;
    int fails = 0;
    int cyc   = 0;
    int g0cyc[2];
    int g1cnt[2];

    task automatic chk(input string tag, input int dd, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, dd, cyc, obs, exp);
        end
    endtask

    task automatic new_req(input int dd, input int m);
        i_req[dd][m]   = 1'b1;
        i_we[dd][m]    = (i_mode == 1) ? 1'b0 : (i_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        i_addr[dd][m]  = AW'($urandom);
        i_wdata[dd][m] = $urandom;
    endtask

    task automatic model_reset(input int dd);
        m_ptr[dd] = 0; m_prevwr[dd] = 0;
        m_cen[dd] = 1; m_wen[dd] = 1; m_oen[dd] = 1;
        m_a[dd] = '0; m_d[dd] = '0;
        m_rd1v[dd] = 0; m_rd1id[dd] = 0; m_rd2v[dd] = 0; m_rd2id[dd] = 0;
        acc_v[dd] = 0; acc_id[dd] = 0; acc_we[dd] = 0;
    endtask

    // One clock cycle: retire last cycle's acceptance into the model, drive
    // this cycle's inputs, then compare every output with the model.
    task automatic step();
        logic r0, r1, sv, sid;
        @(posedge clk);
        #1;
        cyc++;
        for (int dd = 0; dd < 2; dd++) begin
            if (!last_rst) begin
                model_reset(dd);
            end else begin
                m_rd2v[dd]  = m_rd1v[dd];
                m_rd2id[dd] = m_rd1id[dd];
                m_rd1v[dd]  = acc_v[dd] && !acc_we[dd];
                m_rd1id[dd] = acc_id[dd];
                m_prevwr[dd] = acc_v[dd] && acc_we[dd];
                if (acc_v[dd]) begin
                    m_cen[dd] = 0; m_wen[dd] = !acc_we[dd]; m_oen[dd] = acc_we[dd];
                    m_a[dd] = acc_addr[dd];
                    if (acc_we[dd]) m_d[dd] = acc_wdata[dd];
                    m_ptr[dd] = !acc_id[dd];
                end else begin
                    m_cen[dd] = 1; m_wen[dd] = 1; m_oen[dd] = 1;
                end
            end
        end
        rst_n = i_rst;
        for (int dd = 0; dd < 2; dd++) begin
            q[dd] = i_q;
            for (int m = 0; m < 2; m++) begin
                req[dd][m] = i_req[dd][m]; we[dd][m] = i_we[dd][m];
                addr[dd][m] = i_addr[dd][m]; wdata[dd][m] = i_wdata[dd][m];
            end
        end
        #1;
        for (int dd = 0; dd < 2; dd++) begin
            chk("CEN", dd, 64'(cen[dd]), 64'(m_cen[dd]));
            chk("WEN", dd, 64'(wen[dd]), 64'(m_wen[dd]));
            chk("OEN", dd, 64'(oen[dd]), 64'(m_oen[dd]));
            chk("A",   dd, 64'(a[dd]),   64'(m_a[dd]));
            chk("D",   dd, 64'(d[dd]),   64'(m_d[dd]));
            for (int m = 0; m < 2; m++) begin
                chk("rvalid", dd, 64'(rvalid[dd][m]), 64'(m_rd2v[dd] && (int'(m_rd2id[dd]) == m)));
                if (m_rd2v[dd] && int'(m_rd2id[dd]) == m)
                    chk("rdata", dd, 64'(rdata[dd][m]), 64'(i_q));
            end
            // round-robin choice, then the write-to-read hold-off
            r0  = i_req[dd][0] && i_rst;
            r1  = i_req[dd][1] && i_rst;
            sv  = r0 || r1;
            sid = (r0 && r1) ? m_ptr[dd] : !r0;
            if (sv && turn_en[dd] && m_prevwr[dd] && !i_we[dd][sid]) sv = 0;
            chk("gnt0", dd, 64'(gnt[dd][0]), 64'(sv && !sid));
            chk("gnt1", dd, 64'(gnt[dd][1]), 64'(sv && sid));
            acc_v[dd] = sv; acc_id[dd] = sid; acc_we[dd] = i_we[dd][sid];
            acc_addr[dd] = i_addr[dd][sid]; acc_wdata[dd] = i_wdata[dd][sid];
            if (sv) begin
                if (!sid) g0cyc[dd] = cyc; else g1cnt[dd]++;
                if (i_auto[dd][sid]) new_req(dd, int'(sid));
                else i_req[dd][sid] = 0;
            end
        end
        last_rst = i_rst;
    endtask

    task automatic both_req(input int m, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        for (int dd = 0; dd < 2; dd++) begin
            i_req[dd][m] = 1; i_we[dd][m] = w; i_addr[dd][m] = ad; i_wdata[dd][m] = wd;
        end
    endtask

    initial begin
        int t;
        rst_n = 0; i_rst = 0; last_rst = 0; i_q = '0; i_mode = 0;
        for (int dd = 0; dd < 2; dd++) begin
            q[dd] = '0; g0cyc[dd] = -1; g1cnt[dd] = 0;
            model_reset(dd);
            for (int m = 0; m < 2; m++) begin
                i_req[dd][m] = 0; i_we[dd][m] = 0; i_addr[dd][m] = '0; i_wdata[dd][m] = '0;
                i_auto[dd][m] = 0;
                req[dd][m] = 0; we[dd][m] = 0; addr[dd][m] = '0; wdata[dd][m] = '0;
            end
        end

        // reset, with a pending request that must not be granted
        both_req(0, 0, 7'h11, '0);
        step(); step();
        for (int dd = 0; dd < 2; dd++) begin
            chk("rst_CEN", dd, 64'(cen[dd]), 64'd1);
            chk("rst_A",   dd, 64'(a[dd]),   64'd0);
            chk("rst_gnt", dd, 64'(gnt[dd][0]), 64'd0);
            i_req[dd][0] = 0;
        end
        i_rst = 1;
        step();

        // lone m0 read of 0x05
        both_req(0, 0, 7'h05, '0);
        step();
        for (int dd = 0; dd < 2; dd++) chk("rd_gnt", dd, 64'(gnt[dd][0]), 64'd1);
        step();
        for (int dd = 0; dd < 2; dd++) begin
            chk("rd_CEN", dd, 64'(cen[dd]), 64'd0);
            chk("rd_OEN", dd, 64'(oen[dd]), 64'd0);
            chk("rd_A",   dd, 64'(a[dd]),   64'h05);
        end
        i_q = 32'hDEADBEEF;
        step();
        for (int dd = 0; dd < 2; dd++) begin
            chk("rd_rvalid", dd, 64'(rvalid[dd][0]), 64'd1);
            chk("rd_rdata",  dd, 64'(rdata[dd][0]),  64'hDEADBEEF);
        end

        // m1 write then m0 read of the same word, turnaround on and off
        both_req(1, 1, 7'h10, 32'h12345678);
        both_req(0, 0, 7'h10, '0);
        t = cyc + 1;
        for (int k = 0; k < 4; k++) step();
        chk("turn1_rd_gnt", 0, 64'(g0cyc[0]), 64'(t + 2));
        chk("turn0_rd_gnt", 1, 64'(g0cyc[1]), 64'(t + 1));

        // reset lands while a read is in flight
        step();
        both_req(0, 0, 7'h22, '0);
        step();
        i_rst = 0;
        step();
        i_rst = 1;
        step();
        for (int dd = 0; dd < 2; dd++) begin
            chk("rstc_rvalid", dd, 64'(rvalid[dd][0]), 64'd0);
            chk("rstc_OEN",    dd, 64'(oen[dd]),       64'd1);
            chk("rstc_A",      dd, 64'(a[dd]),         64'd0);
        end

        // both stream reads straight out of reset
        i_rst = 0;
        step();
        i_rst = 1; i_mode = 1;
        for (int dd = 0; dd < 2; dd++)
            for (int m = 0; m < 2; m++) begin
                i_auto[dd][m] = 1; new_req(dd, m);
            end
        for (int k = 0; k < 10; k++) begin
            i_q = $urandom;
            step();
        end
        for (int dd = 0; dd < 2; dd++)
            for (int m = 0; m < 2; m++) begin
                i_auto[dd][m] = 0; i_req[dd][m] = 0;
            end
        step(); step();

        // m1 read withdrawn while m0 streams writes
        i_mode = 2;
        for (int dd = 0; dd < 2; dd++) begin
            i_auto[dd][0] = 1; new_req(dd, 0);
        end
        step(); step();
        g1cnt[0] = 0;
        both_req(1, 0, 7'h33, '0);
        step();
        for (int dd = 0; dd < 2; dd++) i_req[dd][1] = 0;
        step(); step(); step();
        chk("withdraw_m1_gnts", 0, 64'(g1cnt[0]), 64'd0);
        for (int dd = 0; dd < 2; dd++) begin
            i_auto[dd][0] = 0; i_req[dd][0] = 0;
        end
        step();

        // random traffic
        i_mode = 0;
        for (int k = 0; k < 600; k++) begin
            i_rst = ($urandom_range(0, 149) != 0);
            i_q   = $urandom;
            for (int dd = 0; dd < 2; dd++)
                for (int m = 0; m < 2; m++) begin
                    if (k % 50 == 0) i_auto[dd][m] = 1'($urandom_range(0, 1));
                    if (i_req[dd][m]) begin
                        if ($urandom_range(0, 9) == 0) i_req[dd][m] = 0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        new_req(dd, m);
                    end
                end
            step();
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
